dot_product_stream: RTL and testbench

Sequential, parametrised successor to the single-cycle signed dot-product unit used in the 2PC embedding flow. The block accepts two magnitude vectors and two sign-share bit-vectors over a valid/ready stream, `LANES` elements per beat. It accumulates sign-resolved products (sign = XOR of the two shares) over `VEC_LEN` elements and returns one result per vector over a valid/ready output with an overflow flag. It sits between the share-decoding front end and the garbled-circuit result serializer.

---
 rtl/dot_pkg.sv | 18 +
 rtl/dot_lane_term.sv | 17 +
 rtl/dot_product_stream.sv | 136 +++++++++++++
 tb/tb_dot_product_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared types and elaboration helpers for the streaming signed dot-product unit.
// The accumulator width is sized so a full vector of worst-case products never wraps.
package dot_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    function automatic int fullWidth(input int elemW, input int vecLen);
        return 2 * elemW + $clog2(vecLen) + 1;
    endfunction

    function automatic bit paramsOk(input int vecLen, input int lanes, input int accW);
        return (lanes > 0) && (vecLen >= lanes) && (vecLen % lanes == 0) && (accW >= 2);
    endfunction

endpackage

// File: rtl/dot_lane_term.sv
// One lane of the dot product: unsigned magnitude product, optionally negated
// when the resolved sign share says the term subtracts.
module dot_lane_term #(
    parameter int ELEM_W = 4
) (
    input  logic [ELEM_W-1:0]        a,
    input  logic [ELEM_W-1:0]        b,
    input  logic                     negate,
    output logic signed [2*ELEM_W:0] term
);

    logic [2*ELEM_W-1:0] prod;

    assign prod = a * b;
    assign term = negate ? -$signed({1'b0, prod}) : $signed({1'b0, prod});

endmodule

// File: rtl/dot_product_stream.sv
// Streaming sign-resolved dot product: LANES elements per beat, one result per
// VEC_LEN elements, delivered on a valid/ready output with an overflow flag.
module dot_product_stream
    import dot_pkg::*;
#(
    parameter int ELEM_W  = 4,
    parameter int VEC_LEN = 10,
    parameter int LANES   = 2,
    parameter int ACC_W   = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   in_a,
    input  logic [LANES*ELEM_W-1:0]   in_b,
    input  logic [LANES-1:0]          in_c,
    input  logic [LANES-1:0]          in_d,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_result,
    output logic                      out_ovf
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int FULL_W = fullWidth(ELEM_W, VEC_LEN);
    localparam int WIDE_W = (FULL_W > ACC_W) ? FULL_W : ACC_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TERM_W = 2 * ELEM_W + 1;

    if (!paramsOk(VEC_LEN, LANES, ACC_W)) begin : gBadParams
        $error("dot_product_stream: VEC_LEN must be a multiple of LANES and ACC_W >= 2");
    end

    state_t                    stateReg;
    logic [CNT_W-1:0]          beatCntReg;
    logic signed [FULL_W-1:0]  accReg;
    logic                      modeReg;
    logic                      inReadyReg;
    logic                      outValidReg;
    logic [ACC_W-1:0]          resultReg;
    logic                      ovfReg;

    logic                      firstBeat;
    logic                      lastBeat;
    logic                      accept;
    logic                      modeEff;
    logic signed [TERM_W-1:0]  laneTerm [LANES];
    logic signed [FULL_W-1:0]  laneSum;
    logic signed [FULL_W-1:0]  accNext;
    logic signed [WIDE_W-1:0]  wideSum;
    logic                      ovfNext;

    assign firstBeat = (beatCntReg == '0);
    assign lastBeat  = (beatCntReg == CNT_W'(BEATS - 1));
    assign accept    = in_valid && inReadyReg;
    // Mode is taken live on beat 0 so the first beat already uses the new vector's mode.
    assign modeEff   = firstBeat ? in_mode : modeReg;

    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        dot_lane_term #(.ELEM_W(ELEM_W)) uLaneTerm (
            .a      (in_a[gi*ELEM_W +: ELEM_W]),
            .b      (in_b[gi*ELEM_W +: ELEM_W]),
            .negate (!modeEff && (in_c[gi] ^ in_d[gi])),
            .term   (laneTerm[gi])
        );
    end

    always_comb begin
        laneSum = '0;
        for (int i = 0; i < LANES; i++) begin
            laneSum = laneSum + FULL_W'(laneTerm[i]);
        end
    end

    assign accNext = (firstBeat ? '0 : accReg) + laneSum;
    assign wideSum = WIDE_W'(accNext);
    // Overflow whenever the low ACC_W bits no longer sign-extend back to the true sum.
    assign ovfNext = (wideSum != WIDE_W'($signed(wideSum[ACC_W-1:0])));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= ACC;
            beatCntReg  <= '0;
            accReg      <= '0;
            modeReg     <= 1'b0;
            inReadyReg  <= 1'b0;
            outValidReg <= 1'b0;
            resultReg   <= '0;
            ovfReg      <= 1'b0;
        end else if (clear) begin
            stateReg    <= ACC;
            beatCntReg  <= '0;
            accReg      <= '0;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
        end else begin
            case (stateReg)
                ACC: begin
                    inReadyReg <= 1'b1;
                    if (accept) begin
                        accReg <= accNext;
                        if (firstBeat) begin
                            modeReg <= in_mode;
                        end
                        if (lastBeat) begin
                            beatCntReg  <= '0;
                            stateReg    <= OUT;
                            inReadyReg  <= 1'b0;
                            outValidReg <= 1'b1;
                            resultReg   <= wideSum[ACC_W-1:0];
                            ovfReg      <= ovfNext;
                        end else begin
                            beatCntReg <= beatCntReg + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        stateReg    <= ACC;
                        inReadyReg  <= 1'b1;
                        outValidReg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready   = inReadyReg;
    assign out_valid  = outValidReg;
    assign out_result = resultReg;
    assign out_ovf    = ovfReg;

endmodule

// File: tb/tb_dot_product_stream.sv
// Scoreboard bench: a default instance and a narrow (ACC_W=12) instance share the
// same stimulus; expected sums are queued on the last accepted beat.
module tb_dot_product_stream;

    localparam int ELEM_W  = 4;
    localparam int VEC_LEN = 10;
    localparam int LANES   = 2;
    localparam int BEATS   = VEC_LEN / LANES;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mode = 1'b0;
    logic        outReady = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_c = '0;
    logic [1:0]  in_d = '0;

    logic        in_ready, out_valid, out_ovf;
    logic [12:0] out_result;
    logic        inReadyN, outValidN, outOvfN;
    logic [11:0] outResultN;

    int nVec = 0;
    int nErr = 0;

    int partSum = 0;
    int beatIdx = 0;
    logic latchedMode = 1'b0;
    int qW[$];
    int qN[$];

    always #5 clk = ~clk;

    dot_product_stream #(.ELEM_W(ELEM_W), .VEC_LEN(VEC_LEN), .LANES(LANES), .ACC_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(outReady), .out_result(out_result), .out_ovf(out_ovf)
    );

    dot_product_stream #(.ELEM_W(ELEM_W), .VEC_LEN(VEC_LEN), .LANES(LANES), .ACC_W(12)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(inReadyN),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mode(in_mode),
        .out_valid(outValidN), .out_ready(outReady), .out_result(outResultN), .out_ovf(outOvfN)
    );

    task automatic checkEq(input string tag, input longint got, input longint exp);
        nVec++;
        if (got != exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint expRes(input int s, input int w);
        return longint'(s) & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint expOvf(input int s, input int w);
        return ((s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)))) ? 1 : 0;
    endfunction

    // Handshake completes at the next posedge when valid&&ready are seen here.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && outReady) begin
            if (qW.size() == 0) begin
                checkEq("w.spurious", qW.size(), 1);
            end else begin
                int s;
                s = qW.pop_front();
                checkEq("w.res", out_result, expRes(s, 13));
                checkEq("w.ovf", out_ovf, expOvf(s, 13));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !clear && outValidN && outReady) begin
            if (qN.size() == 0) begin
                checkEq("n.spurious", qN.size(), 1);
            end else begin
                int s;
                s = qN.pop_front();
                checkEq("n.res", outResultN, expRes(s, 12));
                checkEq("n.ovf", outOvfN, expOvf(s, 12));
            end
        end
    end

    task automatic driveBeat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                             input logic [1:0] d, input logic mode, output int stalls);
        logic m;
        stalls = 0;
        #1;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_d = d; in_mode = mode;
        while (!in_ready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!in_ready) checkEq("beat.timeout", stalls, 0);
        @(posedge clk);
        m = (beatIdx == 0) ? mode : latchedMode;
        if (beatIdx == 0) latchedMode = mode;
        for (int i = 0; i < LANES; i++) begin
            int p;
            p = int'(a[i*ELEM_W +: ELEM_W]) * int'(b[i*ELEM_W +: ELEM_W]);
            partSum += (!m && (c[i] ^ d[i])) ? -p : p;
        end
        beatIdx++;
        if (beatIdx == BEATS) begin
            qW.push_back(partSum);
            qN.push_back(partSum);
            beatIdx = 0;
            partSum = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            #1 in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic sendConst(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                             input logic [1:0] d, input logic mode, output int firstStall);
        int st;
        firstStall = 0;
        for (int k = 0; k < BEATS; k++) begin
            driveBeat(a, b, c, d, mode, st);
            if (k == 0) firstStall = st;
        end
        #1;
        in_valid = 1'b0;
        checkEq("lat.valid", out_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst.ready", in_ready, 0);
        checkEq("rst.valid", out_valid, 0);
        checkEq("rst.res", out_result, 0);
        checkEq("rst.ovf", out_ovf, 0);
        checkEq("rst.n.valid", outValidN, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkEq("rst.ready1", in_ready, 1);
        outReady = 1'b1;

        // All-positive max magnitudes: fits 13 bits, overflows 12 bits.
        sendConst(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0, st);
        checkEq("s1.res", out_result, 13'h08CA);
        checkEq("s1.ovf", out_ovf, 0);
        checkEq("s1.n.res", outResultN, 12'h8CA);
        checkEq("s1.n.ovf", outOvfN, 1);

        sendConst(8'hFF, 8'hFF, 2'b11, 2'b00, 1'b0, st);
        checkEq("s2.res", out_result, 13'h1736);
        checkEq("s2.ovf", out_ovf, 0);

        sendConst(8'hFF, 8'hFF, 2'b11, 2'b00, 1'b1, st);
        checkEq("thru.stall", st, 1);
        checkEq("s3.res", out_result, 13'd2250);

        // Backpressure: hold out_ready low for three OUT cycles.
        idle(1);
        #1 outReady = 1'b0;
        sendConst(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0, st);
        for (int k = 0; k < 3; k++) begin
            checkEq("bp.valid", out_valid, 1);
            checkEq("bp.ready", in_ready, 0);
            checkEq("bp.res", out_result, 13'd2250);
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        checkEq("bp.valid4", out_valid, 1);
        @(posedge clk); #1;
        checkEq("bp.readyAfter", in_ready, 1);
        checkEq("bp.validAfter", out_valid, 0);

        // Clear after two beats, with a competing valid beat during the clear.
        driveBeat(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0, st);
        driveBeat(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0, st);
        #1;
        clear = 1'b1;
        in_valid = 1'b1;
        partSum = 0;
        beatIdx = 0;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        driveBeat(8'h11, 8'h11, 2'b00, 2'b00, 1'b0, st);
        driveBeat(8'h11, 8'h11, 2'b00, 2'b00, 1'b0, st);
        idle(1);
        for (int k = 0; k < 3; k++) driveBeat(8'h11, 8'h11, 2'b00, 2'b00, 1'b0, st);
        #1;
        in_valid = 1'b0;
        checkEq("clr.valid", out_valid, 1);
        checkEq("clr.res", out_result, 13'd10);

        // Asynchronous reset in the middle of a vector.
        idle(1);
        for (int k = 0; k < 3; k++) driveBeat(8'h77, 8'h55, 2'b01, 2'b00, 1'b0, st);
        #1 rst_n = 1'b0;
        partSum = 0;
        beatIdx = 0;
        #1;
        checkEq("amid.valid", out_valid, 0);
        checkEq("amid.ready", in_ready, 0);
        checkEq("amid.res", out_result, 0);
        checkEq("amid.ovf", out_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sendConst(8'h33, 8'h22, 2'b10, 2'b00, 1'b0, st);
        checkEq("amid.after", out_result, 0);

        // Random vectors with gaps; beat mode after beat 0 must be ignored.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < BEATS; k++) begin
                driveBeat(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                          1'($urandom), st);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(12);
        checkEq("drain.w", qW.size(), 0);
        checkEq("drain.n", qN.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
